sha256_msg_padder: RTL

// - Upstream stage of sha256_transform. Accepts a raw message as a stream of 32-bit big-endian words.
// - Applies FIPS 180-4 padding: a 0x80 byte, then zero fill, then the 64-bit message bit length.
// - Emits 512-bit chunks on the chunk_data_vld/rdy/chunk_data interface that sha256_transform consumes.
// - Word 0 of each chunk sits at chunk_data[0].

---
 rtl/sha256_msg_padder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: packs 32-bit big-endian message words into 512-bit chunks,
// inserting the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_vld,
  output logic              msg_rdy,
  input  logic [31:0]       msg_data,
  input  logic              msg_last,
  input  logic [2:0]        msg_bytes,
  output logic              chunk_data_vld,
  input  logic              chunk_data_rdy,
  output logic [15:0][31:0] chunk_data,
  output logic              chunk_first,
  output logic              chunk_last
);

  typedef enum logic [1:0] {StFill, StOut, StOutLast, StXtra} state_e;

  state_e             state_q, state_d;
  logic [15:0][31:0]  buf_q, buf_d;
  logic [3:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d, len_next;
  logic               first_q, first_d;
  logic               pend_q, pend_d;
  logic               padded_q, padded_d;

  logic [2:0]         nbytes;
  logic [5:0]         inc;
  logic [4:0]         pad_pos;
  logic [63:0]        len_fld, len_fld_q;
  logic [31:0]        last_word;

  always_comb begin
    nbytes   = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
    inc      = msg_last ? {nbytes, 3'b000} : 6'd32;
    len_next = len_q + LEN_W'(inc);
    len_fld  = 64'(len_next);
    len_fld_q = 64'(len_q);
    // Marker lands in the following word when the last word is full.
    pad_pos  = {1'b0, idx_q} + ((nbytes == 3'd4) ? 5'd1 : 5'd0);
    last_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes) begin
        last_word[31-8*k -: 8] = msg_data[31-8*k -: 8];
      end else if (3'(k) == nbytes) begin
        last_word[31-8*k -: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    len_d    = len_q;
    first_d  = first_q;
    pend_d   = pend_q;
    padded_d = padded_q;
    unique case (state_q)
      StFill: begin
        if (msg_vld) begin
          len_d = len_next;
          if (!msg_last) begin
            buf_d[idx_q] = msg_data;
            idx_d        = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d = StOut;
            end
          end else begin
            idx_d = '0;
            for (int w = 0; w < 16; w++) begin
              if (4'(w) > idx_q) begin
                buf_d[w] = '0;
              end
            end
            buf_d[idx_q] = last_word;
            if (nbytes == 3'd4 && idx_q != 4'd15) begin
              buf_d[idx_q+4'd1] = 32'h8000_0000;
            end
            if (pad_pos <= 5'd13) begin
              buf_d[14] = len_fld[63:32];
              buf_d[15] = len_fld[31:0];
              state_d   = StOutLast;
            end else begin
              pend_d   = 1'b1;
              padded_d = (pad_pos <= 5'd15);
              state_d  = StOut;
            end
          end
        end
      end
      StOut: begin
        if (chunk_data_rdy) begin
          first_d = 1'b0;
          if (pend_q) begin
            state_d = StXtra;
          end else begin
            state_d = StFill;
            idx_d   = '0;
          end
        end
      end
      StXtra: begin
        buf_d     = '0;
        buf_d[0]  = padded_q ? 32'h0 : 32'h8000_0000;
        buf_d[14] = len_fld_q[63:32];
        buf_d[15] = len_fld_q[31:0];
        pend_d    = 1'b0;
        state_d   = StOutLast;
      end
      StOutLast: begin
        if (chunk_data_rdy) begin
          state_d  = StFill;
          idx_d    = '0;
          len_d    = '0;
          first_d  = 1'b1;
          pend_d   = 1'b0;
          padded_d = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      buf_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      pend_q   <= 1'b0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      padded_q <= padded_d;
    end
  end

  always_comb begin
    msg_rdy        = (state_q == StFill);
    chunk_data_vld = (state_q == StOut) || (state_q == StOutLast);
    chunk_last     = (state_q == StOutLast);
    chunk_first    = first_q && chunk_data_vld;
    chunk_data     = buf_q;
  end

endmodule
